// File: rtl/fft_ks_pkg.sv
// ---------------------------------------------------------------------------
// fft_ks_pkg
// Shared definitions for the FFT butterfly adder scheduler and the pipelined
// Kogge-Stone adder it drives.
//   KS_WIDTH  : datapath width of the shared adder
//   KS_LAT    : accept-to-response latency in cycles
//   KS_LEVELS : number of prefix levels (log2 of KS_WIDTH)
//   sched_state_e : scheduler halt/drain state machine encoding
//   ks_black / ks_grey : prefix-tree combine cells
// ---------------------------------------------------------------------------
package fft_ks_pkg;

    localparam int unsigned KS_WIDTH  = 32;
    localparam int unsigned KS_LAT    = 6;
    localparam int unsigned KS_LEVELS = 5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } sched_state_e;

    // Black cell: combines two (generate, propagate) groups; result {g, p}.
    function automatic logic [1:0] ks_black(input logic g_hi, input logic p_hi,
                                            input logic g_lo, input logic p_lo);
        return {g_hi | (p_hi & g_lo), p_hi & p_lo};
    endfunction

    // Grey cell: used once the lower group already reaches bit 0, so only the
    // generate term is still needed.
    function automatic logic ks_grey(input logic g_hi, input logic p_hi,
                                     input logic g_lo);
        return g_hi | (p_hi & g_lo);
    endfunction

endpackage

// File: rtl/ks_add_pipe.sv
// ---------------------------------------------------------------------------
// ks_add_pipe
// Six-stage pipelined 32-bit Kogge-Stone adder with valid/ID sideband.
//   Stage 0      : bitwise propagate/generate, carry-in folded into bit 0
//   Stages 1..5  : prefix levels with spans 1, 2, 4, 8, 16
//   Stage 6      : sum / carry-out output registers
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_valid, i_id         operation valid and requester tag
//   i_a, i_b, i_cin       operands (B already conditioned) and carry-in
//   o_valid, o_id         response valid pulse and tag
//   o_sum, o_cout         result and carry out of the MSB
//   o_any_valid           at least one operation somewhere in the pipeline
// ---------------------------------------------------------------------------
module ks_add_pipe
    import fft_ks_pkg::*;
#(
    parameter int unsigned IDW = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    input  logic [IDW-1:0]      i_id,
    input  logic [KS_WIDTH-1:0] i_a,
    input  logic [KS_WIDTH-1:0] i_b,
    input  logic                i_cin,
    output logic                o_valid,
    output logic [IDW-1:0]      o_id,
    output logic [KS_WIDTH-1:0] o_sum,
    output logic                o_cout,
    output logic                o_any_valid
);

    localparam int unsigned W = KS_WIDTH;
    localparam int unsigned L = KS_LEVELS;

    // Pipeline registers, index 0 = generation stage, index L = last prefix level.
    logic [W-1:0]   r_p  [0:L];   // bitwise half-sum, needed at the sum stage
    logic [W-1:0]   r_g  [0:L];   // group generate
    logic [W-1:0]   r_gp [0:L];   // group propagate
    logic           r_c  [0:L];   // carry-in, needed for sum bit 0
    logic [IDW-1:0] r_id [0:L];
    logic [L:0]     r_v;

    logic           r_rsp_valid;
    logic [IDW-1:0] r_rsp_id;
    logic [W-1:0]   r_rsp_sum;
    logic           r_rsp_cout;

    logic [W-1:0]   w_p0;
    logic [W-1:0]   w_g0;
    logic [W-1:0]   w_g  [1:L];
    logic [W-1:0]   w_gp [1:L];
    logic [W-1:0]   w_sum;

    // Carry-in is treated as the generate of a virtual bit -1, folded into
    // bit 0 so every prefix level sees it as part of the group-0 generate.
    always_comb begin
        w_p0    = i_a ^ i_b;
        w_g0    = i_a & i_b;
        w_g0[0] = ks_grey(i_a[0] & i_b[0], w_p0[0], i_cin);
    end

    always_comb begin
        int unsigned span;
        span = 0;
        for (int unsigned l = 1; l <= L; l++) begin
            span    = 32'd1 << (l - 1);
            w_g[l]  = r_g[l-1];
            w_gp[l] = r_gp[l-1];
            for (int unsigned i = 0; i < W; i++) begin
                if (i >= span) begin
                    // Lower group already reaches bit 0 -> generate is final.
                    if (i < 2 * span) begin
                        w_g[l][i] = ks_grey(r_g[l-1][i], r_gp[l-1][i],
                                            r_g[l-1][i-span]);
                    end else begin
                        {w_g[l][i], w_gp[l][i]} = ks_black(r_g[l-1][i], r_gp[l-1][i],
                                                          r_g[l-1][i-span], r_gp[l-1][i-span]);
                    end
                end
            end
        end
    end

    // After the last level r_g[L][i] is the carry out of bit i.
    assign w_sum = r_p[L] ^ {r_g[L][W-2:0], r_c[L]};

    // Data path registers: no reset needed, qualified by the valid bits.
    always_ff @(posedge i_clk) begin
        r_p[0]  <= w_p0;
        r_g[0]  <= w_g0;
        r_gp[0] <= w_p0;
        r_c[0]  <= i_cin;
        r_id[0] <= i_id;
        for (int unsigned l = 1; l <= L; l++) begin
            r_p[l]  <= r_p[l-1];
            r_g[l]  <= w_g[l];
            r_gp[l] <= w_gp[l];
            r_c[l]  <= r_c[l-1];
            r_id[l] <= r_id[l-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_v         <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
            r_rsp_cout  <= 1'b0;
        end else begin
            r_v         <= {r_v[L-1:0], i_valid};
            r_rsp_valid <= r_v[L];
            r_rsp_id    <= r_id[L];
            r_rsp_sum   <= w_sum;
            r_rsp_cout  <= r_g[L][W-1];
        end
    end

    assign o_valid     = r_rsp_valid;
    assign o_id        = r_rsp_id;
    assign o_sum       = r_rsp_sum;
    assign o_cout      = r_rsp_cout;
    assign o_any_valid = (|r_v) | r_rsp_valid;

endmodule

// File: rtl/ks_add_sched.sv
// ---------------------------------------------------------------------------
// ks_add_sched
// Round-robin scheduler sharing one pipelined Kogge-Stone adder/subtractor
// between NREQ butterfly requesters, with a halt/drain handshake.
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_req_valid[NREQ]         request valid per requester
//   i_req_a/i_req_b[NREQ*32]  operands, requester k at [32k+31:32k]
//   i_req_sub[NREQ]           1 = A-B, 0 = A+B
//   o_req_ready[NREQ]         one-hot grant, transfer on valid & ready
//   i_halt_req                request pipeline drain and halt
//   o_halted                  pipeline empty and grants stopped
//   o_busy                    operations in flight
//   o_rsp_valid/id/sum/cout   result pulse, requester tag, result, carry out
// ---------------------------------------------------------------------------
module ks_add_sched
    import fft_ks_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NREQ-1:0]          i_req_valid,
    input  logic [NREQ*KS_WIDTH-1:0] i_req_a,
    input  logic [NREQ*KS_WIDTH-1:0] i_req_b,
    input  logic [NREQ-1:0]          i_req_sub,
    output logic [NREQ-1:0]          o_req_ready,
    input  logic                     i_halt_req,
    output logic                     o_halted,
    output logic                     o_busy,
    output logic                     o_rsp_valid,
    output logic [IDW-1:0]           o_rsp_id,
    output logic [KS_WIDTH-1:0]      o_rsp_sum,
    output logic                     o_rsp_cout
);

    sched_state_e          r_state;
    logic [IDW-1:0]        r_ptr;
    logic                  r_halted;
    logic                  r_busy;

    logic [NREQ-1:0]       w_grant;
    logic [IDW-1:0]        w_win;
    logic                  w_xfer;
    logic [KS_WIDTH-1:0]   w_a;
    logic [KS_WIDTH-1:0]   w_b;
    logic                  w_sub;
    logic                  w_any_valid;

    // Round-robin search starting one past the last winner; gated by reset
    // so no transfer can be signalled while the pipeline is being cleared.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        w_grant = '0;
        w_win   = '0;
        w_xfer  = 1'b0;
        if (i_rst_n && (r_state == ST_RUN)) begin
            for (int unsigned off = 1; off <= NREQ; off++) begin
                idx = (32'(r_ptr) + off) % NREQ;
                if (!w_xfer && i_req_valid[idx]) begin
                    w_xfer       = 1'b1;
                    w_grant[idx] = 1'b1;
                    w_win        = IDW'(idx);
                end
            end
        end
    end

    // Subtract is A + ~B + 1; carry-in enters the adder as the bit-0 generate.
    always_comb begin
        w_a   = i_req_a[KS_WIDTH*w_win +: KS_WIDTH];
        w_sub = i_req_sub[w_win];
        w_b   = i_req_b[KS_WIDTH*w_win +: KS_WIDTH];
        if (w_sub) begin
            w_b = ~w_b;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= ST_RUN;
            r_ptr    <= IDW'(NREQ - 1);
            r_halted <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_busy <= w_any_valid;
            if (w_xfer) begin
                r_ptr <= w_win;
            end
            case (r_state)
                ST_RUN: begin
                    if (i_halt_req) begin
                        r_state <= ST_DRAIN;
                    end
                    r_halted <= 1'b0;
                end
                ST_DRAIN: begin
                    if (!i_halt_req) begin
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end else if (!w_any_valid) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (!i_halt_req) begin
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    ks_add_pipe #(
        .IDW (IDW)
    ) u_pipe (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (w_xfer),
        .i_id        (w_win),
        .i_a         (w_a),
        .i_b         (w_b),
        .i_cin       (w_sub),
        .o_valid     (o_rsp_valid),
        .o_id        (o_rsp_id),
        .o_sum       (o_rsp_sum),
        .o_cout      (o_rsp_cout),
        .o_any_valid (w_any_valid)
    );

    assign o_req_ready = w_grant;
    assign o_halted    = r_halted;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_ks_add_sched.sv
// ---------------------------------------------------------------------------
// tb_ks_add_sched
// Scoreboard bench for ks_add_sched: expected results are queued when a
// request is accepted and compared when the response emerges.
// ---------------------------------------------------------------------------
module tb_ks_add_sched;
    import fft_ks_pkg::*;

    localparam int unsigned NREQ = 4;

    typedef struct {
        int unsigned id;
        logic [31:0] sum;
        logic        cout;
        int unsigned stamp;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*32-1:0]   req_a = '0;
    logic [NREQ*32-1:0]   req_b = '0;
    logic [NREQ-1:0]      req_sub = '0;
    logic [NREQ-1:0]      req_ready;
    logic                 halt_req = 1'b0;
    logic                 halted;
    logic                 busy;
    logic                 rsp_valid;
    logic [1:0]           rsp_id;
    logic [31:0]          rsp_sum;
    logic                 rsp_cout;

    exp_t                 sbq[$];
    int unsigned          glog[$];
    int unsigned          n_cmp = 0;
    int unsigned          n_err = 0;
    int unsigned          cyc = 0;
    int unsigned          n_rsp = 0;
    logic [NREQ-1:0]      acc_q = '0;
    bit                   keep_all = 1'b0;
    bit                   rr_phase = 1'b0;
    int unsigned          wait_cnt [NREQ];
    int unsigned          max_wait = 0;

    ks_add_sched #(
        .NREQ (NREQ)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .i_req_sub   (req_sub),
        .o_req_ready (req_ready),
        .i_halt_req  (halt_req),
        .o_halted    (halted),
        .o_busy      (busy),
        .o_rsp_valid (rsp_valid),
        .o_rsp_id    (rsp_id),
        .o_rsp_sum   (rsp_sum),
        .o_rsp_cout  (rsp_cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int unsigned id, input logic [31:0] a,
                                   input logic [31:0] b, input logic sub,
                                   input int unsigned stamp);
        exp_t        e;
        logic [32:0] t;
        e.id    = id;
        e.stamp = stamp;
        if (sub) begin
            e.sum  = a - b;
            e.cout = (a >= b);
        end else begin
            t      = {1'b0, a} + {1'b0, b};
            e.sum  = t[31:0];
            e.cout = t[32];
        end
        return e;
    endfunction

    function automatic logic [31:0] rword();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    // Monitor: check responses, then record acceptances of the coming edge.
    always @(negedge clk) begin
        logic [NREQ-1:0] acc;
        exp_t            e;
        if (rsp_valid) begin
            n_rsp++;
            if (sbq.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
                e = sbq.pop_front();
                chk("rsp_id", 64'(rsp_id), 64'(e.id));
                chk("rsp_sum", 64'(rsp_sum), 64'(e.sum));
                chk("rsp_cout", 64'(rsp_cout), 64'(e.cout));
                chk("rsp_latency", 64'(cyc - e.stamp), 64'(KS_LAT));
            end
        end
        if (halted) begin
            chk("halted_with_pending", 64'(sbq.size()), 64'(0));
        end
        if (req_ready != '0) begin
            chk("grant_onehot", 64'($onehot(req_ready)), 64'(1));
            chk("grant_to_valid", 64'(req_ready & ~req_valid), 64'(0));
        end
        acc = req_valid & req_ready;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (acc[k]) begin
                sbq.push_back(model(k, req_a[32*k +: 32], req_b[32*k +: 32], req_sub[k], cyc + 1));
                glog.push_back(k);
            end
            if (rr_phase) begin
                if (req_valid[k] && !req_ready[k]) begin
                    wait_cnt[k]++;
                    if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
                end else begin
                    wait_cnt[k] = 0;
                end
            end
        end
        acc_q = acc;
    end

    task automatic set_req(input int unsigned k, input logic [31:0] a,
                           input logic [31:0] b, input logic sub);
        req_a[32*k +: 32] = a;
        req_b[32*k +: 32] = b;
        req_sub[k]        = sub;
        req_valid[k]      = 1'b1;
    endtask

    task automatic fill_all();
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!req_valid[k]) set_req(k, rword(), rword(), 1'($urandom_range(0, 1)));
        end
    endtask

    // Advance one cycle; accepted requests drop valid after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc_q;
        if (keep_all) fill_all();
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60 && (sbq.size() != 0 || req_valid != '0); i++) step();
        chk(tag, 64'(sbq.size()), 64'(0));
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        keep_all = 1'b0;
        sbq.delete();
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'(0));
        @(posedge clk);
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_id", 64'(rsp_id), 64'(0));
        chk("rst_rsp_sum", 64'(rsp_sum), 64'(0));
        chk("rst_rsp_cout", 64'(rsp_cout), 64'(0));
        chk("rst_halted", 64'(halted), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        rst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r0;
        int unsigned g1;

        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single add: 1 + 0xFFFFFFFF wraps to 0 with carry out.
        set_req(0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        chk("single_grant", 64'(req_ready), 64'(4'b0001));
        r0 = n_rsp;
        step();
        wait_drain("single_drain");
        chk("single_count", 64'(n_rsp - r0), 64'(1));

        // Subtracts on requester 2, borrow and no-borrow.
        r0 = n_rsp;
        set_req(2, 32'd5, 32'd7, 1'b1);
        step();
        set_req(2, 32'd7, 32'd5, 1'b1);
        step();
        wait_drain("sub_drain");
        chk("sub_count", 64'(n_rsp - r0), 64'(2));

        // Fairness from reset with all requesters valid.
        do_reset();
        glog.delete();
        keep_all = 1'b1;
        fill_all();
        repeat (12) step();
        keep_all = 1'b0;
        wait_drain("rr_drain");
        for (int i = 0; i < 12; i++) chk("rr_order", 64'(glog[i]), 64'(i % 4));

        // Halt with four operations in flight.
        do_reset();
        keep_all = 1'b1;
        fill_all();
        repeat (4) step();
        chk("busy_inflight", 64'(busy), 64'(1));
        r0       = n_rsp;
        halt_req = 1'b1;
        @(negedge clk);
        chk("halt_cycle_grant", 64'(req_ready != '0), 64'(1));
        step();
        chk("drain_not_halted", 64'(halted), 64'(0));
        g1 = glog.size();
        for (int i = 0; i < 40 && !halted; i++) step();
        chk("halt_reached", 64'(halted), 64'(1));
        chk("halt_no_grant", 64'(glog.size() - g1), 64'(0));
        chk("halt_rsp_count", 64'(n_rsp - r0), 64'(5));
        chk("halt_busy", 64'(busy), 64'(0));
        halt_req = 1'b0;
        @(negedge clk);
        chk("halt_release_cycle", 64'(req_ready), 64'(0));
        step();
        @(negedge clk);
        chk("resume_grant", 64'(req_ready != '0), 64'(1));
        keep_all = 1'b0;
        wait_drain("halt_drain");

        // Reset with three operations in flight; pointer left at 2.
        do_reset();
        set_req(0, rword(), rword(), 1'b0);
        set_req(1, rword(), rword(), 1'b1);
        set_req(2, rword(), rword(), 1'b0);
        repeat (3) step();
        chk("busy_before_rst", 64'(busy), 64'(1));
        fill_all();
        do_reset();
        @(negedge clk);
        chk("post_rst_grant", 64'(req_ready), 64'(4'b0001));
        step();
        chk("post_rst_busy", 64'(busy), 64'(0));
        wait_drain("post_rst_drain");

        // Random traffic with starvation tracking.
        for (int unsigned k = 0; k < NREQ; k++) wait_cnt[k] = 0;
        max_wait = 0;
        rr_phase = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (!req_valid[k] && ($urandom_range(0, 1) == 1))
                    set_req(k, rword(), rword(), 1'($urandom_range(0, 1)));
            end
            step();
        end
        rr_phase = 1'b0;
        wait_drain("rand_drain");
        chk("max_wait_bound", 64'(max_wait <= NREQ - 1), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
